// File: rtl/twiddle_cmult.sv
// Pipelined sign-magnitude complex multiplier P = B x W for the FFT butterfly.
// Optional round-half-up on the partial products: define TWIDDLE_CMULT_ROUND_EN.
module twiddle_cmult #(
    parameter int N = 20,
    parameter int Q = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] b_re,
    input  logic [N-1:0] b_im,
    input  logic [N-1:0] w_re,
    input  logic [N-1:0] w_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] p_re,
    output logic [N-1:0] p_im,
    output logic         out_sat
);
    localparam int M  = N - 1;
    localparam int PW = 2 * M;
    localparam logic [M-1:0] SAT_MAG = {{(M - Q){1'b1}}, {Q{1'b0}}};

    typedef struct packed {
        logic         sat;
        logic         sign;
        logic [M-1:0] mag;
    } sm_t;

    // Fixed-point product of two sign-magnitude words, clamped to SAT_MAG.
    function automatic sm_t mul_sm(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [PW-1:0] prod;
        logic [PW-1:0] shifted;
        sm_t           r;
        prod = PW'(x[M-1:0]) * PW'(y[M-1:0]);
`ifdef TWIDDLE_CMULT_ROUND_EN
        prod = prod + (PW'(1) << (Q - 1));
`endif
        shifted = prod >> Q;
        r.sat   = (shifted >= PW'(SAT_MAG));
        r.mag   = r.sat ? SAT_MAG : shifted[M-1:0];
        r.sign  = (x[N-1] ^ y[N-1]) & (r.mag != '0);
        return r;
    endfunction

    // Sign-magnitude addition matching the downstream add_fixed rules.
    function automatic sm_t add_sm(input logic sa, input logic [M-1:0] ma,
                                   input logic sb, input logic [M-1:0] mb);
        logic [M:0] sum;
        logic       sign;
        sm_t        r;
        if (sa == sb) begin
            sum  = {1'b0, ma} + {1'b0, mb};
            sign = sa;
        end else if (ma >= mb) begin
            sum  = {1'b0, ma - mb};
            sign = sa;
        end else begin
            sum  = {1'b0, mb - ma};
            sign = sb;
        end
        r.sat  = (sum >= {1'b0, SAT_MAG});
        r.mag  = r.sat ? SAT_MAG : sum[M-1:0];
        r.sign = sign & (r.mag != '0);
        return r;
    endfunction

    logic         en;
    logic         s1_valid_q, s1_valid_d;
    logic [N-1:0] s1_b_re_q, s1_b_re_d;
    logic [N-1:0] s1_b_im_q, s1_b_im_d;
    logic [N-1:0] s1_w_re_q, s1_w_re_d;
    logic [N-1:0] s1_w_im_q, s1_w_im_d;
    logic         s2_valid_q, s2_valid_d;
    sm_t          rr_q, rr_d;
    sm_t          ii_q, ii_d;
    sm_t          ri_q, ri_d;
    sm_t          ir_q, ir_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] p_re_q, p_re_d;
    logic [N-1:0] p_im_q, p_im_d;
    logic         out_sat_q, out_sat_d;
    sm_t          re_sum;
    sm_t          im_sum;

    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;

    // Real part subtracts ii, so its sign is inverted before the combine.
    always_comb begin
        re_sum = add_sm(rr_q.sign, rr_q.mag, ~ii_q.sign, ii_q.mag);
        im_sum = add_sm(ri_q.sign, ri_q.mag, ir_q.sign, ir_q.mag);
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_b_re_d   = s1_b_re_q;
        s1_b_im_d   = s1_b_im_q;
        s1_w_re_d   = s1_w_re_q;
        s1_w_im_d   = s1_w_im_q;
        s2_valid_d  = s2_valid_q;
        rr_d        = rr_q;
        ii_d        = ii_q;
        ri_d        = ri_q;
        ir_d        = ir_q;
        out_valid_d = out_valid_q;
        p_re_d      = p_re_q;
        p_im_d      = p_im_q;
        out_sat_d   = out_sat_q;
        if (en) begin
            s1_valid_d  = in_valid;
            s1_b_re_d   = b_re;
            s1_b_im_d   = b_im;
            s1_w_re_d   = w_re;
            s1_w_im_d   = w_im;
            s2_valid_d  = s1_valid_q;
            rr_d        = mul_sm(s1_b_re_q, s1_w_re_q);
            ii_d        = mul_sm(s1_b_im_q, s1_w_im_q);
            ri_d        = mul_sm(s1_b_re_q, s1_w_im_q);
            ir_d        = mul_sm(s1_b_im_q, s1_w_re_q);
            out_valid_d = s2_valid_q;
            p_re_d      = {re_sum.sign, re_sum.mag};
            p_im_d      = {im_sum.sign, im_sum.mag};
            out_sat_d   = rr_q.sat | ii_q.sat | ri_q.sat | ir_q.sat
                        | re_sum.sat | im_sum.sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_b_re_q   <= '0;
            s1_b_im_q   <= '0;
            s1_w_re_q   <= '0;
            s1_w_im_q   <= '0;
            s2_valid_q  <= 1'b0;
            rr_q        <= '0;
            ii_q        <= '0;
            ri_q        <= '0;
            ir_q        <= '0;
            out_valid_q <= 1'b0;
            p_re_q      <= '0;
            p_im_q      <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_b_re_q   <= s1_b_re_d;
            s1_b_im_q   <= s1_b_im_d;
            s1_w_re_q   <= s1_w_re_d;
            s1_w_im_q   <= s1_w_im_d;
            s2_valid_q  <= s2_valid_d;
            rr_q        <= rr_d;
            ii_q        <= ii_d;
            ri_q        <= ri_d;
            ir_q        <= ir_d;
            out_valid_q <= out_valid_d;
            p_re_q      <= p_re_d;
            p_im_q      <= p_im_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign p_re      = p_re_q;
    assign p_im      = p_im_q;
    assign out_sat   = out_sat_q;

endmodule
